// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register-access master: FSM state encoding,
// frame bit positions and a helper that packs a command into a 16-bit frame.
// Frame layout (MSB first): [15] rw, [14:8] addr, [7:0] data.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_FRAME_BITS = 16;
    localparam int SPI_RW_BIT     = 15;
    localparam int SPI_ADDR_MSB   = 14;
    localparam int SPI_ADDR_LSB   = 8;
    localparam int SPI_ADDR_W     = SPI_ADDR_MSB - SPI_ADDR_LSB + 1;
    localparam int SPI_DATA_W     = SPI_ADDR_LSB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } spi_state_e;

    function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
        input logic                  rw,
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] wdata
    );
        logic [SPI_FRAME_BITS-1:0] f;
        f                            = '0;
        f[SPI_RW_BIT]                = rw;
        f[SPI_ADDR_MSB:SPI_ADDR_LSB] = addr;
        f[SPI_DATA_W-1:0]            = wdata;
        return f;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// -----------------------------------------------------------------------------
// spi_master_if
// Command/response handshake and SPI pin bundle for spi_master.
//  master modport (the SPI master itself):
//   in : cmd_valid, cmd_rw, cmd_addr[6:0], cmd_wdata[7:0], spi_miso
//   out: cmd_ready, rsp_valid, rsp_rdata[7:0], busy, spi_clk, spi_cs_n, spi_mosi
//  slave modport: the mirror image (command sequencer + SPI slave side).
// -----------------------------------------------------------------------------
interface spi_master_if;
    import spi_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rw;
    logic [SPI_ADDR_W-1:0] cmd_addr;
    logic [SPI_DATA_W-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [SPI_DATA_W-1:0] rsp_rdata;
    logic                  busy;
    logic                  spi_clk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, spi_miso,
        output cmd_ready, rsp_valid, rsp_rdata, busy, spi_clk, spi_cs_n, spi_mosi
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, spi_miso,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, spi_clk, spi_cs_n, spi_mosi
    );

endinterface

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// SPI clock generator: half-period down-counter that toggles spi_clk every
// CLK_DIV sys_clk cycles while enabled. Held low with a full count while
// disabled, so the first half-period after enable is always a full low phase.
//  clk_i        in   system clock
//  rst_i        in   synchronous reset, active-high
//  en_i         in   run the clock (SHIFT state)
//  spi_clk_o    out  SPI clock, idles low
//  rise_tick_o  out  spi_clk goes high at the next clk_i edge
//  fall_tick_o  out  spi_clk goes low at the next clk_i edge
// -----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic spi_clk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);
    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          edge_w;

    assign edge_w      = en_i && (cnt_q == '0);
    assign rise_tick_o = edge_w && !clk_q;
    assign fall_tick_o = edge_w && clk_q;
    assign spi_clk_o   = clk_q;

    always_comb begin
        cnt_d = CW'(CLK_DIV - 1);
        clk_d = 1'b0;
        if (en_i) begin
            clk_d = clk_q ^ edge_w;
            cnt_d = edge_w ? CW'(CLK_DIV - 1) : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CW'(CLK_DIV - 1);
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Single-channel SPI mode-0 master turning register read/write commands into
// 16-bit frames {rw, addr[6:0], data[7:0]}, MSB first, one at a time.
//  sys_clk  in   system clock, rising edge
//  sys_rst  in   synchronous reset, active-high
//  bus      spi_master_if.master: command handshake, response, SPI pins
// Parameters: CLK_DIV (spi_clk half-period), CS_SETUP, CS_HOLD (sys_clk cycles).
// Build option SPI_MASTER_LOOPBACK_EN: receive path takes spi_mosi instead of
// the spi_miso pin (board self-test); timing is unchanged.
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    spi_master_if.master  bus
);
    // One width wide enough for the setup/hold counter and the gap counter.
    localparam int CW = $clog2(CLK_DIV + CS_SETUP + CS_HOLD + 1);

    spi_state_e                state_q, state_d;
    logic [SPI_FRAME_BITS-1:0] tx_q, tx_d;
    logic [SPI_DATA_W-1:0]     rx_q, rx_d;
    logic [SPI_DATA_W-1:0]     rdata_q, rdata_d;
    logic [3:0]                bit_q, bit_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [CW-1:0]             gap_q, gap_d;
    logic                      cs_n_q, cs_n_d;
    logic                      accept_w, rise_w, fall_w, miso_w;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso_w = tx_q[SPI_FRAME_BITS-1];
`else
    assign miso_w = bus.spi_miso;
`endif

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .en_i        (state_q == ST_SHIFT),
        .spi_clk_o   (bus.spi_clk),
        .rise_tick_o (rise_w),
        .fall_tick_o (fall_w)
    );

    assign bus.cmd_ready = (state_q == ST_IDLE) && (gap_q == '0);
    assign accept_w      = bus.cmd_valid && bus.cmd_ready;
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.spi_cs_n  = cs_n_q;
    assign bus.spi_mosi  = tx_q[SPI_FRAME_BITS-1];

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        cs_n_d  = cs_n_q;

        // Only 8 bits kept: after 16 samples they hold the byte1 response.
        if (rise_w) rx_d = {rx_q[SPI_DATA_W-2:0], miso_w};

        unique case (state_q)
            ST_IDLE: begin
                if (gap_q != '0) gap_d = gap_q - 1'b1;
                if (accept_w) begin
                    tx_d    = spi_frame(bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata);
                    bit_d   = '0;
                    cnt_d   = CW'(CS_SETUP - 1);
                    cs_n_d  = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) state_d = ST_SHIFT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_SHIFT: begin
                if (fall_w) begin
                    bit_d = bit_q + 1'b1;  // wraps 15 -> 0 on the last bit
                    if (bit_q == 4'(SPI_FRAME_BITS - 1)) begin
                        cnt_d   = CW'(CS_HOLD - 1);
                        state_d = ST_HOLD;
                    end else begin
                        // mosi is the tx MSB, so the last bit stays on the pin
                        tx_d = tx_q << 1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d  = 1'b1;
                    rdata_d = rx_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                gap_d   = CW'(CLK_DIV);  // minimum cs_n-high time before next accept
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= CW'(CLK_DIV);
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            cs_n_q  <= cs_n_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master: default-timing instance (CLK_DIV=4,
// CS_SETUP=2, CS_HOLD=2) plus a fast instance (all 1). A small mode-0 slave
// model per instance shifts in mosi on spi_clk rise and presents miso bits.
// -----------------------------------------------------------------------------
module tb_spi_master;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    spi_master_if bus_a ();
    spi_master_if bus_b ();

    spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u_dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus_a)
    );

    spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_fast (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus_b)
    );

    // Slave model A: counts rises, collects mosi, serves a_stx MSB first.
    int          a_rises = 0;
    logic [15:0] a_frame = '0;
    logic [15:0] a_stx   = '0;
    always @(posedge bus_a.spi_clk or negedge bus_a.spi_cs_n) begin
        if (bus_a.spi_clk) begin
            a_frame <= {a_frame[14:0], bus_a.spi_mosi};
            a_rises <= a_rises + 1;
        end else begin
            a_frame <= '0;
            a_rises <= 0;
        end
    end
    assign bus_a.spi_miso = (a_rises < 16) ? a_stx[4'(15 - a_rises)] : 1'b0;

    // Slave model B: miso tied low.
    int          b_rises = 0;
    logic [15:0] b_frame = '0;
    always @(posedge bus_b.spi_clk or negedge bus_b.spi_cs_n) begin
        if (bus_b.spi_clk) begin
            b_frame <= {b_frame[14:0], bus_b.spi_mosi};
            b_rises <= b_rises + 1;
        end else begin
            b_frame <= '0;
            b_rises <= 0;
        end
    end
    assign bus_b.spi_miso = 1'b0;

    task automatic drive_cmd_a(input logic rw, input logic [6:0] addr, input logic [7:0] wd);
        bus_a.cmd_rw    = rw;
        bus_a.cmd_addr  = addr;
        bus_a.cmd_wdata = wd;
        bus_a.cmd_valid = 1'b1;
    endtask

    // One command on A; lat = cycles from the accept cycle to rsp_valid.
    // Command inputs are inverted right after accept to prove they are latched.
    task automatic xact_a(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                          output int lat, output logic [7:0] rdata);
        int k;
        @(negedge clk);
        drive_cmd_a(rw, addr, wd);
        k = 0;
        while (bus_a.cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        bus_a.cmd_rw    = ~rw;
        bus_a.cmd_addr  = ~addr;
        bus_a.cmd_wdata = ~wd;
        lat = 1;
        while (bus_a.rsp_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
        rdata = bus_a.rsp_rdata;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        int          w;
        repeat (3) @(negedge clk);
        obs = {bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.busy,
               bus_a.spi_clk, bus_a.spi_cs_n, bus_a.spi_mosi};
        n_vec++;
        if (obs !== 14'h0002) begin
            n_err++;
            $display("FAIL reset_a {rdy,rv,rdata,busy,clk,csn,mosi}: got %b want %b", obs, 14'h0002);
        end
        obs = {bus_b.cmd_ready, bus_b.rsp_valid, bus_b.rsp_rdata, bus_b.busy,
               bus_b.spi_clk, bus_b.spi_cs_n, bus_b.spi_mosi};
        n_vec++;
        if (obs !== 14'h0002) begin
            n_err++;
            $display("FAIL reset_b {rdy,rv,rdata,busy,clk,csn,mosi}: got %b want %b", obs, 14'h0002);
        end
        rst = 1'b0;
        w = 0;
        while (bus_a.cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        n_vec++;
        if (w !== 4) begin
            n_err++;
            $display("FAIL reset_gap: ready after %0d cycles, want 4", w);
        end
    endtask

    task automatic test_write();
        int         lat;
        logic [7:0] rd;
        a_stx = 16'h0000;
        xact_a(1'b0, 7'h15, 8'hA5, lat, rd);
        n_vec++;
        if (lat !== 133) begin n_err++; $display("FAIL write_lat: got %0d want 133", lat); end
        n_vec++;
        if (a_frame !== 16'h15A5) begin n_err++; $display("FAIL write_frame: got %h want 15a5", a_frame); end
        n_vec++;
        if (a_rises !== 16) begin n_err++; $display("FAIL write_rises: got %0d want 16", a_rises); end
        @(negedge clk);
        n_vec++;
        if ({bus_a.rsp_valid, bus_a.spi_cs_n} !== 2'b01) begin
            n_err++;
            $display("FAIL write_after {rv,csn}: got %b want 01", {bus_a.rsp_valid, bus_a.spi_cs_n});
        end
    endtask

    task automatic test_read();
        int         lat;
        logic [7:0] rd, exp_rd;
        a_stx = 16'h005C;
`ifdef SPI_MASTER_LOOPBACK_EN
        exp_rd = 8'h96;
`else
        exp_rd = 8'h5C;
`endif
        xact_a(1'b1, 7'h03, 8'h96, lat, rd);
        n_vec++;
        if (a_frame[15:8] !== 8'h83) begin n_err++; $display("FAIL read_byte0: got %h want 83", a_frame[15:8]); end
        n_vec++;
        if (rd !== exp_rd) begin n_err++; $display("FAIL read_rdata: got %h want %h", rd, exp_rd); end
        n_vec++;
        if (lat !== 133) begin n_err++; $display("FAIL read_lat: got %0d want 133", lat); end
    endtask

    task automatic test_back_to_back();
        int          k, cyc, cs_rise, acc, bad, rises1, lat;
        logic        prev_cs;
        logic [15:0] frame1;
        a_stx = 16'h0000;
        @(negedge clk);
        drive_cmd_a(1'b0, 7'h2A, 8'h11);
        k = 0;
        while (bus_a.cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        drive_cmd_a(1'b0, 7'h55, 8'h22);  // valid stays high
        cyc = 1; cs_rise = -1; acc = -1; bad = 0; rises1 = 0; frame1 = '0;
        prev_cs = bus_a.spi_cs_n;
        while (acc < 0 && cyc < 400) begin
            if (bus_a.busy === 1'b1 && bus_a.cmd_ready !== 1'b0) bad++;
            if (prev_cs === 1'b0 && bus_a.spi_cs_n === 1'b1 && cs_rise < 0) begin
                cs_rise = cyc;
                frame1  = a_frame;
                rises1  = a_rises;
            end
            prev_cs = bus_a.spi_cs_n;
            if (bus_a.cmd_ready === 1'b1) acc = cyc;
            else begin @(negedge clk); cyc++; end
        end
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        lat = 1;
        while (bus_a.rsp_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL b2b_ready_busy: %0d cycles ready while busy, want 0", bad); end
        n_vec++;
        if (!(cs_rise >= 0 && acc >= 0 && (acc - cs_rise) >= 4)) begin
            n_err++;
            $display("FAIL b2b_gap: accept %0d cycles after cs_n rise, want >= 4", acc - cs_rise);
        end
        n_vec++;
        if (frame1 !== 16'h2A11 || rises1 !== 16) begin
            n_err++;
            $display("FAIL b2b_first: frame %h rises %0d, want 2a11 16", frame1, rises1);
        end
        n_vec++;
        if (a_frame !== 16'h5522 || lat !== 133) begin
            n_err++;
            $display("FAIL b2b_second: frame %h lat %0d, want 5522 133", a_frame, lat);
        end
    endtask

    task automatic test_reset_midframe();
        int         k, seen, lat;
        logic [7:0] rd;
        a_stx = 16'h0000;
        @(negedge clk);
        drive_cmd_a(1'b0, 7'h7F, 8'h0F);
        k = 0;
        while (bus_a.cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        k = 0;
        while (a_rises < 8 && k < 300) begin @(negedge clk); k++; end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus_a.spi_cs_n, bus_a.spi_clk, bus_a.spi_mosi, bus_a.rsp_valid} !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_pins {csn,clk,mosi,rv}: got %b want 1000",
                     {bus_a.spi_cs_n, bus_a.spi_clk, bus_a.spi_mosi, bus_a.rsp_valid});
        end
        rst = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus_a.rsp_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL midrst_rsp: %0d rsp_valid pulses, want 0", seen); end
        xact_a(1'b0, 7'h01, 8'hFF, lat, rd);
        n_vec++;
        if (a_frame !== 16'h01FF || a_rises !== 16) begin
            n_err++;
            $display("FAIL midrst_next: frame %h rises %0d, want 01ff 16", a_frame, a_rises);
        end
        n_vec++;
        if (lat !== 133) begin n_err++; $display("FAIL midrst_lat: got %0d want 133", lat); end
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback();
        int         lat;
        logic [7:0] rd;
        a_stx = 16'h0000;
        xact_a(1'b1, 7'h40, 8'h3C, lat, rd);
        n_vec++;
        if (rd !== 8'h3C) begin n_err++; $display("FAIL loopback_rdata: got %h want 3c", rd); end
        n_vec++;
        if (a_rises !== 16) begin n_err++; $display("FAIL loopback_rises: got %0d want 16", a_rises); end
    endtask
`endif

    task automatic test_fast();
        int         k, lat, toggles;
        logic       prev;
        logic [7:0] exp_rd;
`ifdef SPI_MASTER_LOOPBACK_EN
        exp_rd = 8'hC3;
`else
        exp_rd = 8'h00;
`endif
        @(negedge clk);
        bus_b.cmd_rw    = 1'b0;
        bus_b.cmd_addr  = 7'h5A;
        bus_b.cmd_wdata = 8'hC3;
        bus_b.cmd_valid = 1'b1;
        k = 0;
        while (bus_b.cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        lat = 1; toggles = 0;
        prev = bus_b.spi_clk;
        while (bus_b.rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus_b.spi_clk !== prev) toggles++;
            prev = bus_b.spi_clk;
        end
        n_vec++;
        if (lat !== 35) begin n_err++; $display("FAIL fast_lat: got %0d want 35", lat); end
        n_vec++;
        if (toggles !== 32) begin n_err++; $display("FAIL fast_toggles: got %0d want 32", toggles); end
        n_vec++;
        if (b_rises !== 16 || b_frame !== 16'h5AC3) begin
            n_err++;
            $display("FAIL fast_frame: frame %h rises %0d, want 5ac3 16", b_frame, b_rises);
        end
        n_vec++;
        if (bus_b.rsp_rdata !== exp_rd) begin
            n_err++;
            $display("FAIL fast_rdata: got %h want %h", bus_b.rsp_rdata, exp_rd);
        end
    endtask

    initial begin
        bus_a.cmd_valid = 1'b0; bus_a.cmd_rw = 1'b0; bus_a.cmd_addr = '0; bus_a.cmd_wdata = '0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_rw = 1'b0; bus_b.cmd_addr = '0; bus_b.cmd_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_midframe();
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        test_fast();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
